// File: rtl/sobel_stream_2d.sv
// Streaming 3x3 Sobel engine: two line buffers feed a sliding window. Results come from
// interior windows only and leave through a registered valid/ready stage.
module sobel_stream_2d #(
   parameter int unsigned WIDTH_P  = 8,
   parameter int unsigned LINE_W_P = 16,
   parameter int unsigned HEIGHT_P = 16,
   parameter int unsigned GRAD_W_P = WIDTH_P + 3
) (
   input  logic                       clk_i,
   input  logic                       rstn_i,
   input  logic                       valid_i,
   output logic                       ready_o,
   input  logic [WIDTH_P-1:0]         data_i,
   input  logic                       sof_i,
   output logic                       valid_o,
   input  logic                       ready_i,
   output logic signed [GRAD_W_P-1:0] gx_o,
   output logic signed [GRAD_W_P-1:0] gy_o,
   output logic [WIDTH_P-1:0]         mag_o,
   output logic                       last_o
);

   localparam int unsigned COL_W = $clog2(LINE_W_P);
   localparam int unsigned ROW_W = $clog2(HEIGHT_P);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_W_P - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT_P - 1);
   localparam logic [GRAD_W_P:0] MAG_MAX =
      {{(GRAD_W_P + 1 - WIDTH_P){1'b0}}, {WIDTH_P{1'b1}}};

   logic [COL_W-1:0]           r_col;
   logic [COL_W-1:0]           w_col_eff;
   logic [COL_W-1:0]           w_col_nxt;
   logic [ROW_W-1:0]           r_row;
   logic [ROW_W-1:0]           w_row_eff;
   logic [ROW_W-1:0]           w_row_nxt;
   logic                       w_accept;
   logic                       w_win_valid;
   logic                       w_last;

   logic [WIDTH_P-1:0]         r_lb0 [LINE_W_P];
   logic [WIDTH_P-1:0]         r_lb1 [LINE_W_P];
   logic [WIDTH_P-1:0]         w_lb0_rd;
   logic [WIDTH_P-1:0]         w_lb1_rd;

   logic [WIDTH_P-1:0]         r_win [3][3];
   logic [WIDTH_P-1:0]         w_win [3][3];

   logic signed [GRAD_W_P-1:0] w_gx;
   logic signed [GRAD_W_P-1:0] w_gy;
   logic [GRAD_W_P-1:0]        w_abs_gx;
   logic [GRAD_W_P-1:0]        w_abs_gy;
   logic [GRAD_W_P:0]          w_sum;
   logic [WIDTH_P-1:0]         w_mag;

   logic                       r_valid;
   logic signed [GRAD_W_P-1:0] r_gx;
   logic signed [GRAD_W_P-1:0] r_gy;
   logic [WIDTH_P-1:0]         r_mag;
   logic                       r_last;

   function automatic logic signed [GRAD_W_P-1:0] ext(input logic [WIDTH_P-1:0] p);
      return $signed({{(GRAD_W_P - WIDTH_P){1'b0}}, p});
   endfunction

   assign ready_o  = ready_i | ~r_valid;
   assign w_accept = valid_i & ready_o;

   // sof_i re-anchors the current pixel at the frame origin
   assign w_col_eff = sof_i ? '0 : r_col;
   assign w_row_eff = sof_i ? '0 : r_row;

   assign w_win_valid = (w_col_eff >= COL_W'(2)) && (w_row_eff >= ROW_W'(2));
   assign w_last      = (w_col_eff == COL_LAST) && (w_row_eff == ROW_LAST);

   always_comb begin
      w_col_nxt = w_col_eff + COL_W'(1);
      w_row_nxt = w_row_eff;
      if (w_col_eff == COL_LAST) begin
         w_col_nxt = '0;
         w_row_nxt = (w_row_eff == ROW_LAST) ? '0 : w_row_eff + ROW_W'(1);
      end
   end

   assign w_lb0_rd = r_lb0[w_col_eff];
   assign w_lb1_rd = r_lb1[w_col_eff];

   always_comb begin
      for (int r = 0; r < 3; r++) begin
         w_win[r][0] = r_win[r][1];
         w_win[r][1] = r_win[r][2];
      end
      w_win[0][2] = w_lb0_rd;
      w_win[1][2] = w_lb1_rd;
      w_win[2][2] = data_i;
   end

   // Gradients use the window as it will look after this accept
   always_comb begin
      w_gx = (ext(w_win[0][2]) + (ext(w_win[1][2]) <<< 1) + ext(w_win[2][2]))
           - (ext(w_win[0][0]) + (ext(w_win[1][0]) <<< 1) + ext(w_win[2][0]));
      w_gy = (ext(w_win[2][0]) + (ext(w_win[2][1]) <<< 1) + ext(w_win[2][2]))
           - (ext(w_win[0][0]) + (ext(w_win[0][1]) <<< 1) + ext(w_win[0][2]));
      w_abs_gx = w_gx[GRAD_W_P-1] ? -w_gx : w_gx;
      w_abs_gy = w_gy[GRAD_W_P-1] ? -w_gy : w_gy;
      w_sum    = {1'b0, w_abs_gx} + {1'b0, w_abs_gy};
      w_mag    = (w_sum > MAG_MAX) ? {WIDTH_P{1'b1}} : w_sum[WIDTH_P-1:0];
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_col <= '0;
         r_row <= '0;
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
               r_win[r][c] <= '0;
            end
         end
      end else if (w_accept) begin
         r_col <= w_col_nxt;
         r_row <= w_row_nxt;
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
               r_win[r][c] <= w_win[r][c];
            end
         end
      end
   end

   // Line buffers are never cleared; interior gating keeps stale lines off the output
   always_ff @(posedge clk_i) begin
      if (w_accept) begin
         r_lb0[w_col_eff] <= w_lb1_rd;
         r_lb1[w_col_eff] <= data_i;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_valid <= 1'b0;
         r_gx    <= '0;
         r_gy    <= '0;
         r_mag   <= '0;
         r_last  <= 1'b0;
      end else if (w_accept && w_win_valid) begin
         r_valid <= 1'b1;
         r_gx    <= w_gx;
         r_gy    <= w_gy;
         r_mag   <= w_mag;
         r_last  <= w_last;
      end else if (ready_i) begin
         r_valid <= 1'b0;
      end
   end

   assign valid_o = r_valid;
   assign gx_o    = r_gx;
   assign gy_o    = r_gy;
   assign mag_o   = r_mag;
   assign last_o  = r_last;

endmodule

// File: tb/tb_sobel_stream_2d.sv
// Randomised bench for sobel_stream_2d on a 4x4 frame: an image-level Sobel model feeds a
// scoreboard, and literal expectations pin the constant, ramp and edge frames.
module tb_sobel_stream_2d;

   localparam int unsigned LW = 4;
   localparam int unsigned HT = 4;
   localparam int unsigned WD = 8;
   localparam int unsigned GW = WD + 3;

   logic                 clk_i   = 1'b0;
   logic                 rstn_i  = 1'b0;
   logic                 valid_i = 1'b0;
   logic                 ready_o;
   logic [WD-1:0]        data_i  = '0;
   logic                 sof_i   = 1'b0;
   logic                 valid_o;
   logic                 ready_i = 1'b1;
   logic signed [GW-1:0] gx_o;
   logic signed [GW-1:0] gy_o;
   logic [WD-1:0]        mag_o;
   logic                 last_o;

   int checks   = 0;
   int failures = 0;
   int rdy_mode = 0;
   bit gaps_en  = 0;

   int img [HT][LW];
   int pos_r = 0;
   int pos_c = 0;
   int exp_gx[$], exp_gy[$], exp_mag[$];
   bit exp_last[$];
   int log_gx[$], log_gy[$], log_mag[$];
   bit log_last[$];

   bit                   prev_stall = 0;
   logic signed [GW-1:0] prev_gx, prev_gy;
   logic [WD-1:0]        prev_mag;
   logic                 prev_last;

   sobel_stream_2d #(
      .WIDTH_P  (WD),
      .LINE_W_P (LW),
      .HEIGHT_P (HT),
      .GRAD_W_P (GW)
   ) u_dut (
      .clk_i   (clk_i),
      .rstn_i  (rstn_i),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .data_i  (data_i),
      .sof_i   (sof_i),
      .valid_o (valid_o),
      .ready_i (ready_i),
      .gx_o    (gx_o),
      .gy_o    (gy_o),
      .mag_o   (mag_o),
      .last_o  (last_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   always @(negedge clk_i) begin
      case (rdy_mode)
         1:       ready_i = ~ready_i;
         2:       ready_i = 1'($urandom_range(0, 1));
         default: ready_i = 1'b1;
      endcase
   end

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   // Image-level model: the 3x3 neighbourhood ending at the accepted pixel
   task automatic model_accept(input int pix, input bit sof);
      int p [3][3];
      int gx, gy, m;
      if (sof) begin
         pos_r = 0;
         pos_c = 0;
      end
      img[pos_r][pos_c] = pix;
      if (pos_r >= 2 && pos_c >= 2) begin
         for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
               p[i][j] = img[pos_r - 2 + i][pos_c - 2 + j];
         gx = (p[0][2] + 2 * p[1][2] + p[2][2]) - (p[0][0] + 2 * p[1][0] + p[2][0]);
         gy = (p[2][0] + 2 * p[2][1] + p[2][2]) - (p[0][0] + 2 * p[0][1] + p[0][2]);
         m  = iabs(gx) + iabs(gy);
         if (m > 255) m = 255;
         exp_gx.push_back(gx);
         exp_gy.push_back(gy);
         exp_mag.push_back(m);
         exp_last.push_back(pos_r == HT - 1 && pos_c == LW - 1);
      end
      pos_c++;
      if (pos_c == LW) begin
         pos_c = 0;
         pos_r = (pos_r + 1) % HT;
      end
   endtask

   always @(negedge clk_i) begin
      #1;
      if (!rstn_i) begin
         prev_stall = 0;
      end else begin
         if (prev_stall) begin
            checks++;
            if (valid_o !== 1'b1 || gx_o !== prev_gx || gy_o !== prev_gy ||
                mag_o !== prev_mag || last_o !== prev_last) begin
               failures++;
               $display("FAIL hold: got v=%b gx=%0d gy=%0d mag=%0d last=%b, need v=1 gx=%0d gy=%0d mag=%0d last=%b",
                        valid_o, gx_o, gy_o, mag_o, last_o, prev_gx, prev_gy, prev_mag, prev_last);
            end
         end
         if (valid_o === 1'b1 && ready_i === 1'b0) begin
            checks++;
            if (ready_o !== 1'b0) begin
               failures++;
               $display("FAIL ready_stall: got ready_o=%b, need 0", ready_o);
            end
         end
         if (valid_o === 1'b1 && ready_i === 1'b1) begin
            log_gx.push_back(int'(gx_o));
            log_gy.push_back(int'(gy_o));
            log_mag.push_back(int'(mag_o));
            log_last.push_back(last_o);
            checks++;
            if (exp_gx.size() == 0) begin
               failures++;
               $display("FAIL unexpected_result: got gx=%0d gy=%0d mag=%0d, need no result",
                        gx_o, gy_o, mag_o);
            end else begin
               int egx, egy, emag;
               bit elast;
               egx   = exp_gx.pop_front();
               egy   = exp_gy.pop_front();
               emag  = exp_mag.pop_front();
               elast = exp_last.pop_front();
               if (int'(gx_o) != egx || int'(gy_o) != egy || int'(mag_o) != emag ||
                   last_o !== elast) begin
                  failures++;
                  $display("FAIL result: got gx=%0d gy=%0d mag=%0d last=%b, need gx=%0d gy=%0d mag=%0d last=%b",
                           gx_o, gy_o, mag_o, last_o, egx, egy, emag, elast);
               end
            end
         end
         prev_stall = (valid_o === 1'b1 && ready_i === 1'b0);
         prev_gx    = gx_o;
         prev_gy    = gy_o;
         prev_mag   = mag_o;
         prev_last  = last_o;
      end
   end

   // Called at a falling edge; returns at a falling edge
   task automatic send(input int pix, input bit sof);
      int waited;
      int idle;
      bit acc;
      if (gaps_en) begin
         idle = $urandom_range(0, 2);
         repeat (idle) begin
            valid_i = 1'b0;
            sof_i   = 1'b0;
            @(negedge clk_i);
         end
      end
      valid_i = 1'b1;
      data_i  = pix[WD-1:0];
      sof_i   = sof;
      waited  = 0;
      acc     = 0;
      while (!acc && waited < 100) begin
         #1;
         acc = ready_o;
         @(posedge clk_i);
         if (!acc) begin
            @(negedge clk_i);
            waited++;
         end
      end
      if (acc) begin
         model_accept(pix, sof);
      end else begin
         checks++;
         failures++;
         $display("FAIL send_timeout: got no accept in %0d cycles, need accept", waited);
      end
      @(negedge clk_i);
      valid_i = 1'b0;
      sof_i   = 1'b0;
   endtask

   function automatic int pix_of(input int kind, input int r, input int c);
      case (kind)
         0:       return 100;
         1:       return 10 * c;
         2:       return (c < 2) ? 0 : 255;
         3:       return (r < 2) ? 0 : 255;
         4:       return $urandom_range(0, 255);
         default: return 255 * $urandom_range(0, 1);
      endcase
   endfunction

   task automatic send_frame(input int kind, input bit sof_first);
      for (int r = 0; r < HT; r++)
         for (int c = 0; c < LW; c++)
            send(pix_of(kind, r, c), sof_first && r == 0 && c == 0);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_gx.size() != 0 && n < 200) begin
         @(negedge clk_i);
         n++;
      end
      repeat (3) @(negedge clk_i);
      checks++;
      if (exp_gx.size() != 0) begin
         failures++;
         $display("FAIL drain: got %0d results outstanding, need 0", exp_gx.size());
      end
      rdy_mode = 0;
      gaps_en  = 0;
   endtask

   task automatic clear_log();
      log_gx.delete();
      log_gy.delete();
      log_mag.delete();
      log_last.delete();
   endtask

   task automatic check_log(input string name, input int n, input int gx, input int gy,
                            input int mag);
      checks++;
      if (log_gx.size() != n) begin
         failures++;
         $display("FAIL %s_count: got %0d results, need %0d", name, log_gx.size(), n);
      end
      for (int i = 0; i < log_gx.size(); i++) begin
         checks++;
         if (log_gx[i] != gx || log_gy[i] != gy || log_mag[i] != mag ||
             log_last[i] != (i == n - 1)) begin
            failures++;
            $display("FAIL %s[%0d]: got gx=%0d gy=%0d mag=%0d last=%b, need gx=%0d gy=%0d mag=%0d last=%b",
                     name, i, log_gx[i], log_gy[i], log_mag[i], log_last[i], gx, gy, mag,
                     (i == n - 1));
         end
      end
   endtask

   task automatic check_zero(input string name);
      checks++;
      if (valid_o !== 1'b0 || gx_o !== '0 || gy_o !== '0 || mag_o !== '0 || last_o !== 1'b0) begin
         failures++;
         $display("FAIL %s: got v=%b gx=%0d gy=%0d mag=%0d last=%b, need all 0",
                  name, valid_o, gx_o, gy_o, mag_o, last_o);
      end
   endtask

   initial begin
      repeat (2) @(negedge clk_i);
      #1;
      check_zero("reset_outputs");
      @(negedge clk_i);
      rstn_i = 1'b1;
      @(negedge clk_i);

      clear_log();
      send_frame(0, 1'b1);
      drain();
      check_log("const", 4, 0, 0, 0);

      clear_log();
      send_frame(1, 1'b1);
      drain();
      check_log("ramp", 4, 80, 0, 80);

      clear_log();
      send_frame(2, 1'b1);
      drain();
      check_log("vedge", 4, 1020, 0, 255);

      clear_log();
      send_frame(3, 1'b1);
      drain();
      check_log("hedge", 4, 0, 1020, 255);

      clear_log();
      rdy_mode = 1;
      gaps_en  = 1;
      send_frame(1, 1'b1);
      drain();
      check_log("ramp_bp", 4, 80, 0, 80);

      for (int f = 0; f < 6; f++) begin
         rdy_mode = 2;
         gaps_en  = (f % 2 == 0);
         send_frame((f < 3) ? 4 : 5, 1'b1);
         drain();
      end

      clear_log();
      for (int i = 0; i < 6; i++)
         send(pix_of(4, i / LW, i % LW), i == 0);
      send_frame(1, 1'b1);
      drain();
      check_log("sof_restart", 4, 80, 0, 80);

      for (int i = 0; i < 11; i++)
         send(pix_of(1, i / LW, i % LW), i == 0);
      rstn_i = 1'b0;
      #1;
      check_zero("mid_reset");
      exp_gx.delete();
      exp_gy.delete();
      exp_mag.delete();
      exp_last.delete();
      pos_r = 0;
      pos_c = 0;
      @(negedge clk_i);
      rstn_i = 1'b1;
      @(negedge clk_i);
      clear_log();
      send_frame(1, 1'b0);
      drain();
      check_log("post_reset", 4, 80, 0, 80);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sobel_stream_2d.md
Name: sobel_stream_2d

Overview:
- Streaming 3x3 Sobel engine for raster-scan pixel streams with a parametrised line length and frame height.
- Holds two line buffers and a 3x3 window, and tracks column and row position.
- Emits gradients and magnitude only for fully interior windows, so stale buffer contents never reach the output.
- Sits between the pixel source and the edge-threshold stage; the output is a registered valid/ready stage with full backpressure.

Parameters:
- WIDTH_P, 8: unsigned pixel width.
- LINE_W_P, 16: pixels per line; must be >= 3.
- HEIGHT_P, 16: lines per frame; must be >= 3.
- GRAD_W_P, WIDTH_P+3: signed gradient width; holds +/-4*(2^WIDTH_P-1).

Ports:
- clk_i  in  1  clock, rising edge.
- rstn_i  in  1  reset, asynchronous, active-low.
- valid_i  in  1  input pixel valid.
- ready_o  out  1  input ready.
- data_i  in  WIDTH_P  unsigned pixel, raster order.
- sof_i  in  1  start of frame; qualifies the pixel on data_i as (row 0, col 0).
- valid_o  out  1  output result valid.
- ready_i  in  1  downstream ready.
- gx_o  out  GRAD_W_P  signed horizontal gradient.
- gy_o  out  GRAD_W_P  signed vertical gradient.
- mag_o  out  WIDTH_P  |gx|+|gy|, saturated to 2^WIDTH_P-1.
- last_o  out  1  marks the final interior result of the frame.

Behaviour:
- Reset: one clock (clk_i); rstn_i is asynchronous, active-low. Assertion clears valid_o, gx_o, gy_o, mag_o, last_o, the window, and the col/row counters to 0. Line-buffer RAM is not cleared.
- Handshakes:
  - Pixel accept = valid_i & ready_o.
  - Result accept = valid_o & ready_i.
  - ready_o = ready_i | ~valid_o. This is combinational; there is no skid buffer.
- Per accepted pixel:
  - The window shifts left by one column.
  - Column 2 loads the line-buffer outputs: row 0 = two lines ago, row 1 = one line ago, row 2 = data_i.
  - The pixel is written to the line buffers, addressed by col.
- Counters:
  - col increments per accepted pixel and wraps LINE_W_P-1 -> 0.
  - On wrap, row increments; row wraps HEIGHT_P-1 -> 0.
  - If sof_i is set on an accepted pixel, that pixel is treated as col=0, row=0 and counters continue from there.
  - A frame truncated by sof_i produces no further results. Buffer contents are reused and are never exposed, because of the interior gating below.
- Window rule: the window is valid after the accept when the accepted pixel has col>=2 and row>=2. Its centre is (row-1, col-1). The window never spans a line wrap.
- Result generation:
  - On an accept producing a valid window, the next edge registers gx, gy, mag and last, and sets valid_o. Latency is 1 cycle from accept.
  - Results per frame = (LINE_W_P-2)*(HEIGHT_P-2).
- Arithmetic: pixels are zero-extended to signed.
  - gx = (p02+2*p12+p22) - (p00+2*p10+p20).
  - gy = (p20+2*p21+p22) - (p00+2*p01+p02).
  - Indices are [row][col]; row 0 is oldest, col 0 is oldest.
  - mag = min(|gx|+|gy|, 2^WIDTH_P-1), computed at GRAD_W_P+1 bits before saturation.
- last_o is set with the result whose source pixel is col=LINE_W_P-1, row=HEIGHT_P-1.
- Backpressure: while valid_o & ~ready_i, all outputs hold stable, ready_o=0, and no pixel is accepted.
- Simultaneous result accept and new valid window: the output register reloads in the same edge and valid_o stays 1.
- Result accept with no new valid window: valid_o clears next edge.
- Reset mid-frame behaves as power-up: the first results come only after two full new lines.

Test Plan:
- Constant image, every pixel 100, 4x4 (LINE_W_P=4, HEIGHT_P=4), valid_i always 1, ready_i=1 -> exactly 4 results, all gx=0, gy=0, mag=0; last_o only on the 4th.
- Horizontal ramp, pixel = 10*col, 4x4 -> 4 results each gx=80, gy=0, mag=80.
- Vertical edge, cols 0,1=0 and cols 2,3=255, 4x4 -> gx=1020 at both interior columns, gy=0, mag=255 (saturated).
- Horizontal edge, rows 0,1=0 and rows 2,3=255, 4x4 -> gy=1020, gx=0, mag=255.
- Backpressure: ramp frame with ready_i toggled 1010... and random valid_i gaps -> identical ordered result sequence to the unstalled run, outputs stable while stalled, no pixel lost.
- Robustness: sof_i mid-frame (after 6 pixels), then rstn_i pulsed during a later frame; each followed by a clean 4x4 ramp -> no results before row 2 col 2 of the new frame, then exactly 4 correct results (gx=80); outputs read 0 during reset.
